// File: rtl/commit_pc_checker_pkg.sv
// Shared definitions for the commit PC checker: error codes, checker
// states and the sequential PC increment.
package commit_pc_checker_pkg;

    localparam logic [1:0] ERR_NONE           = 2'd0;
    localparam logic [1:0] ERR_PC_MISMATCH    = 2'd1;
    localparam logic [1:0] ERR_LANE_GAP       = 2'd2;
    localparam logic [1:0] ERR_BRANCH_IN_SLOT = 2'd3;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SLOT = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/commit_trace_fifo.sv
// Multi-push / single-pop circular buffer of committed PCs.
// Pushes are all-or-nothing per cycle; a cycle that does not fit sets a
// sticky overflow flag. Free space is judged after this cycle's pop.
module commit_trace_fifo #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            push_n_i,
    input  logic [LANES*XLEN-1:0] push_pc_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [XLEN-1:0]       pc_o,
    output logic                  overflow_o
);
    localparam int AW = $clog2(DEPTH);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q, free_w;
    logic            ovf_q, pop_w, push_ok_w;

    assign pop_w     = (cnt_q != '0) && ready_i;
    assign free_w    = (AW+1)'(DEPTH) - cnt_q + {{AW{1'b0}}, pop_w};
    assign push_ok_w = int'(push_n_i) <= int'(free_w);

    // Pointer/occupancy bookkeeping and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (pop_w)
                rd_q <= rd_q + 1'b1;
            if (push_ok_w) begin
                wr_q  <= wr_q + AW'(push_n_i);
                cnt_q <= cnt_q + (AW+1)'(push_n_i) - {{AW{1'b0}}, pop_w};
            end else begin
                cnt_q <= cnt_q - {{AW{1'b0}}, pop_w};
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage writes: accepted lanes land in consecutive slots, lane order
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (push_ok_w && (3'(i) < push_n_i))
                mem_q[wr_q + AW'(i)] <= push_pc_i[i*XLEN +: XLEN];
    end

    assign valid_o    = (cnt_q != '0);
    assign pc_o       = mem_q[rd_q];
    assign overflow_o = ovf_q;

endmodule

// File: rtl/commit_pc_checker.sv
// Lockstep retire-stage monitor: checks committed PCs against the expected
// MIPS flow (with delay slots) across LANES commit ports per cycle, counts
// commits/branches/taken branches and latches the first error.
// Optional trace FIFO of accepted PCs under COMMIT_TRACE_FIFO_EN.
module commit_pc_checker
    import commit_pc_checker_pkg::*;
#(
    parameter int              LANES          = 2,
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              CNT_W          = 32,
    parameter int              TARGET_COMMITS = 20000
`ifdef COMMIT_TRACE_FIFO_EN
    ,
    parameter int              TRACE_DEPTH    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      commit_valid,
    input  logic [LANES*XLEN-1:0] commit_pc,
    input  logic [LANES-1:0]      commit_is_branch,
    input  logic [LANES-1:0]      commit_taken,
    input  logic [LANES*XLEN-1:0] commit_target,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [1:0]            err_lane,
    output logic [XLEN-1:0]       err_pc,
    output logic [XLEN-1:0]       err_exp_pc,
    output logic [CNT_W-1:0]      commit_cnt,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      taken_cnt,
    output logic                  done
`ifdef COMMIT_TRACE_FIFO_EN
    ,
    output logic                  trace_valid,
    output logic [XLEN-1:0]       trace_pc,
    input  logic                  trace_ready,
    output logic                  trace_overflow
`endif
);

    state_e          st_q, st_d;
    logic [XLEN-1:0] exp_q, exp_d, tgt_q, tgt_d;
    logic            tkn_q, tkn_d;
    logic            err_q, err_d, done_q;
    logic [1:0]      code_q, code_d, lane_q, lane_d;
    logic [XLEN-1:0] epc_q, epc_d, eexp_q, eexp_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d, bcnt_q, bcnt_d, tcnt_q, tcnt_d;
    logic [2:0]      acc_n;
    logic [XLEN-1:0] pc_w;
    logic [1:0]      lcode_w;
    logic            gap_w, stop_w;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Lane chain, oldest first: each lane sees the state left by the ones before it
    always_comb begin
        st_d   = st_q;
        exp_d  = exp_q;
        tgt_d  = tgt_q;
        tkn_d  = tkn_q;
        err_d  = err_q;
        code_d = code_q;
        lane_d = lane_q;
        epc_d  = epc_q;
        eexp_d = eexp_q;
        ccnt_d = ccnt_q;
        bcnt_d = bcnt_q;
        tcnt_d = tcnt_q;
        acc_n  = 3'd0;
        pc_w   = '0;
        lcode_w = ERR_NONE;
        gap_w  = 1'b0;
        stop_w = (st_q == HALT);
        for (int i = 0; i < LANES; i++) begin
            pc_w = commit_pc[i*XLEN +: XLEN];
            if (!stop_w) begin
                if (!commit_valid[i]) begin
                    gap_w = 1'b1;
                end else begin
                    if (gap_w)
                        lcode_w = ERR_LANE_GAP;
                    else if (pc_w != exp_d)
                        lcode_w = ERR_PC_MISMATCH;
                    else if (st_d == SLOT && commit_is_branch[i])
                        lcode_w = ERR_BRANCH_IN_SLOT;
                    else
                        lcode_w = ERR_NONE;

                    if (lcode_w != ERR_NONE) begin
                        // first error only; lanes above are dropped
                        stop_w = 1'b1;
                        st_d   = HALT;
                        err_d  = 1'b1;
                        code_d = lcode_w;
                        lane_d = 2'(i);
                        epc_d  = pc_w;
                        eexp_d = exp_d;
                    end else begin
                        ccnt_d = sat_inc(ccnt_d);
                        acc_n  = acc_n + 3'd1;
                        if (st_d == SLOT) begin
                            exp_d = tkn_d ? tgt_d : exp_d + XLEN'(PC_INC);
                            st_d  = RUN;
                        end else begin
                            exp_d = exp_d + XLEN'(PC_INC);
                            if (commit_is_branch[i]) begin
                                tgt_d  = commit_target[i*XLEN +: XLEN];
                                tkn_d  = commit_taken[i];
                                st_d   = SLOT;
                                bcnt_d = sat_inc(bcnt_d);
                                if (commit_taken[i])
                                    tcnt_d = sat_inc(tcnt_d);
                            end
                        end
                    end
                end
            end
        end
    end

    // Checker state, error record, counters; done trails commit_cnt by a cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= RUN;
            exp_q  <= RESET_PC;
            tgt_q  <= '0;
            tkn_q  <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
            lane_q <= '0;
            epc_q  <= '0;
            eexp_q <= '0;
            ccnt_q <= '0;
            bcnt_q <= '0;
            tcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            exp_q  <= exp_d;
            tgt_q  <= tgt_d;
            tkn_q  <= tkn_d;
            err_q  <= err_d;
            code_q <= code_d;
            lane_q <= lane_d;
            epc_q  <= epc_d;
            eexp_q <= eexp_d;
            ccnt_q <= ccnt_d;
            bcnt_q <= bcnt_d;
            tcnt_q <= tcnt_d;
            done_q <= (ccnt_q > CNT_W'(TARGET_COMMITS));
        end
    end

    assign err        = err_q;
    assign err_code   = code_q;
    assign err_lane   = lane_q;
    assign err_pc     = epc_q;
    assign err_exp_pc = eexp_q;
    assign commit_cnt = ccnt_q;
    assign branch_cnt = bcnt_q;
    assign taken_cnt  = tcnt_q;
    assign done       = done_q;

`ifdef COMMIT_TRACE_FIFO_EN
    // Accepted lanes always form a prefix 0..acc_n-1, so PCs go in unshuffled
    commit_trace_fifo #(
        .LANES (LANES),
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk        (clk),
        .rst        (rst),
        .push_n_i   (acc_n),
        .push_pc_i  (commit_pc),
        .ready_i    (trace_ready),
        .valid_o    (trace_valid),
        .pc_o       (trace_pc),
        .overflow_o (trace_overflow)
    );
`else
    // Accepted-lane count only feeds the trace path
    logic unused_acc_n;
    assign unused_acc_n = ^acc_n;
`endif

endmodule

// File: tb/tb_commit_pc_checker.sv
// Directed bench for commit_pc_checker (LANES=2, TARGET_COMMITS=10).
// Trace FIFO section is compiled when COMMIT_TRACE_FIFO_EN is defined.
module tb_commit_pc_checker;
    localparam int LANES = 2;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [LANES-1:0]      cv = '0, cb = '0, ct = '0;
    logic [LANES*XLEN-1:0] cpc = '0, ctg = '0;
    logic            err, done;
    logic [1:0]      err_code, err_lane;
    logic [XLEN-1:0] err_pc, err_exp_pc;
    logic [31:0]     commit_cnt, branch_cnt, taken_cnt;
`ifdef COMMIT_TRACE_FIFO_EN
    logic            trace_valid, trace_ready = 1'b0, trace_overflow;
    logic [XLEN-1:0] trace_pc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    commit_pc_checker #(
        .LANES(LANES), .XLEN(XLEN), .RESET_PC(32'h0), .CNT_W(32), .TARGET_COMMITS(10)
`ifdef COMMIT_TRACE_FIFO_EN
        , .TRACE_DEPTH(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .commit_valid(cv), .commit_pc(cpc), .commit_is_branch(cb),
        .commit_taken(ct), .commit_target(ctg),
        .err(err), .err_code(err_code), .err_lane(err_lane),
        .err_pc(err_pc), .err_exp_pc(err_exp_pc),
        .commit_cnt(commit_cnt), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt),
        .done(done)
`ifdef COMMIT_TRACE_FIFO_EN
        , .trace_valid(trace_valid), .trace_pc(trace_pc),
        .trace_ready(trace_ready), .trace_overflow(trace_overflow)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one commit cycle; returns at posedge+1 with lanes idle again
    task automatic cyc(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] br, input logic [1:0] tk,
                       input logic [31:0] t0, input logic [31:0] t1);
        cv = v; cpc = {p1, p0}; cb = br; ct = tk; ctg = {t1, t0};
        @(posedge clk); #1;
        cv = '0; cb = '0; ct = '0;
    endtask

    // async pulse between clock edges
    task automatic do_reset;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_cnt", commit_cnt, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

`ifdef COMMIT_TRACE_FIFO_EN
        cyc(2'b11, 32'h0,  32'h4,  2'b00, 2'b00, 0, 0);
        cyc(2'b11, 32'h8,  32'hC,  2'b00, 2'b00, 0, 0);
        cyc(2'b11, 32'h10, 32'h14, 2'b00, 2'b00, 0, 0);
        chk("tr_ovf", trace_overflow, 1);
        chk("tr_cnt", commit_cnt, 6);
        chk("tr_valid", trace_valid, 1);
        trace_ready = 1'b1;
        chk("tr_pc0", trace_pc, 32'h0);
        @(posedge clk); #1; chk("tr_pc1", trace_pc, 32'h4);
        @(posedge clk); #1; chk("tr_pc2", trace_pc, 32'h8);
        @(posedge clk); #1; chk("tr_pc3", trace_pc, 32'hC);
        @(posedge clk); #1; chk("tr_empty", trace_valid, 0);
        trace_ready = 1'b0;
        do_reset();
        chk("tr_rst_ovf", trace_overflow, 0);
        chk("tr_rst_valid", trace_valid, 0);
`endif

        // sequential pairs
        cyc(2'b11, 32'h0,  32'h4,  2'b00, 2'b00, 0, 0);
        cyc(2'b11, 32'h8,  32'hC,  2'b00, 2'b00, 0, 0);
        cyc(2'b11, 32'h10, 32'h14, 2'b00, 2'b00, 0, 0);
        chk("seq_cnt", commit_cnt, 6);
        chk("seq_err", err, 0);
        cyc(2'b11, 32'h18, 32'h1C, 2'b00, 2'b00, 0, 0);
        chk("seq_exp18", err, 0);
        chk("seq_cnt8", commit_cnt, 8);

        // JAL in lane1, slot + target next cycle
        cyc(2'b11, 32'h20, 32'h24, 2'b10, 2'b10, 0, 32'h100);
        chk("jal_cnt", commit_cnt, 10);
        chk("jal_br", branch_cnt, 1);
        chk("jal_tk", taken_cnt, 1);
        cyc(2'b11, 32'h28, 32'h100, 2'b00, 2'b00, 0, 0);
        chk("jal_err", err, 0);
        chk("jal_cnt2", commit_cnt, 12);
        chk("done_lag", done, 0);
        @(posedge clk); #1;
        chk("done_set", done, 1);
        chk("idle_cnt", commit_cnt, 12);

        // BNE not taken, then single lane
        cyc(2'b11, 32'h104, 32'h108, 2'b01, 2'b00, 32'h200, 0);
        cyc(2'b01, 32'h10C, 32'h0,   2'b00, 2'b00, 0, 0);
        chk("nt_err", err, 0);
        chk("nt_cnt", commit_cnt, 15);
        chk("nt_br", branch_cnt, 2);
        chk("nt_tk", taken_cnt, 1);

        // BEQ taken with slot in same cycle, then wrong PC
        cyc(2'b11, 32'h110, 32'h114, 2'b01, 2'b01, 32'h40, 0);
        chk("beq_cnt", commit_cnt, 17);
        chk("beq_tk", taken_cnt, 2);
        cyc(2'b11, 32'h18, 32'h44, 2'b00, 2'b00, 0, 0);
        chk("mm_err", err, 1);
        chk("mm_code", err_code, 1);
        chk("mm_lane", err_lane, 0);
        chk("mm_pc", err_pc, 32'h18);
        chk("mm_exp", err_exp_pc, 32'h40);
        chk("mm_cnt", commit_cnt, 17);
        cyc(2'b11, 32'h40, 32'h44, 2'b00, 2'b00, 0, 0);
        chk("halt_cnt", commit_cnt, 17);
        chk("halt_pc", err_pc, 32'h18);

        do_reset();
        chk("rst2_err", err, 0);
        chk("rst2_cnt", commit_cnt, 0);
        chk("rst2_br", branch_cnt, 0);
        chk("rst2_done", done, 0);

        // lane gap
        cyc(2'b10, 32'h0, 32'h4, 2'b00, 2'b00, 0, 0);
        chk("gap_code", err_code, 2);
        chk("gap_lane", err_lane, 1);
        chk("gap_pc", err_pc, 32'h4);
        chk("gap_exp", err_exp_pc, 32'h0);
        chk("gap_cnt", commit_cnt, 0);

        // branch in delay slot
        do_reset();
        cyc(2'b11, 32'h0, 32'h4, 2'b11, 2'b01, 32'h80, 32'h90);
        chk("bis_code", err_code, 3);
        chk("bis_lane", err_lane, 1);
        chk("bis_exp", err_exp_pc, 32'h4);
        chk("bis_cnt", commit_cnt, 1);
        chk("bis_br", branch_cnt, 1);

        // reset while a delay slot is pending
        do_reset();
        cyc(2'b11, 32'h0, 32'h4, 2'b10, 2'b10, 0, 32'h80);
        do_reset();
        cyc(2'b11, 32'h0, 32'h4, 2'b00, 2'b00, 0, 0);
        chk("rslot_err", err, 0);
        chk("rslot_cnt", commit_cnt, 2);

        // PC wraps past all-ones
        cyc(2'b11, 32'h8, 32'hC, 2'b01, 2'b01, 32'hFFFF_FFFC, 0);
        cyc(2'b11, 32'hFFFF_FFFC, 32'h0, 2'b00, 2'b00, 0, 0);
        cyc(2'b01, 32'h4, 32'h0, 2'b00, 2'b00, 0, 0);
        chk("wrap_err", err, 0);
        chk("wrap_cnt", commit_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
